// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and helpers for the multiply/divide sequencer
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_ITERS = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Two's-complement negate; the most negative value maps onto itself.
  function automatic logic [MULDIV_WIDTH-1:0] twos_neg(input logic [MULDIV_WIDTH-1:0] x);
    return ~x + MULDIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - 32-step signed shift-add multiply / restoring divide writing HI/LO
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // opa_q holds the raw rs operand; opb_q holds raw rt until PREP, then |rt|
  // (multiplicand or divisor). acc_q is the upper accumulator / remainder,
  // work_q the multiplier (becoming the product low word) or the quotient.
  logic [2:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Next-state logic for the FSM, datapath and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    acc_d      = acc_q;
    work_d     = work_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    sum        = {1'b0, acc_q} + (work_q[0] ? {1'b0, opb_q} : '0);
    rem_sh     = {acc_q, work_q[WIDTH-1]};
    diff       = rem_sh - {1'b0, opb_q};

    case (state_q)
      ST_IDLE: begin
        if (mult_start || div_start) begin
          op_d    = mult_start ? OP_MULT : OP_DIV;
          opa_d   = a;
          opb_d   = b;
          busy_d  = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        sign_a_d = opa_q[WIDTH-1];
        sign_b_d = opb_q[WIDTH-1];
        work_d   = opa_q[WIDTH-1] ? twos_neg(opa_q) : opa_q;
        opb_d    = opb_q[WIDTH-1] ? twos_neg(opb_q) : opb_q;
        acc_d    = '0;
        cnt_d    = '0;
        if (op_q == OP_DIV && opb_q == '0) begin
          // HI/LO are left untouched; only the flag reports the fault.
          busy_d     = 1'b0;
          done_d     = 1'b1;
          div_zero_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        if (op_q == OP_MULT) begin
          // The add carry becomes the new top bit after the right shift.
          acc_d  = sum[WIDTH:1];
          work_d = {sum[0], work_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
          acc_d  = diff[WIDTH-1:0];
          work_d = {work_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d  = rem_sh[WIDTH-1:0];
          work_d = {work_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MULDIV_ITERS - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (op_q == OP_MULT) begin
          if (sign_a_q != sign_b_q) begin
            // 64-bit negate split in halves: carry into HI only when LO is zero.
            lo_d = twos_neg(work_q);
            hi_d = ~acc_q + WIDTH'(work_q == '0);
          end else begin
            lo_d = work_q;
            hi_d = acc_q;
          end
        end else begin
          lo_d = (sign_a_q != sign_b_q) ? twos_neg(work_q) : work_q;
          hi_d = sign_a_q ? twos_neg(acc_q) : acc_q;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides any in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      opa_q      <= '0;
      opb_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      acc_q      <= '0;
      work_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      acc_q      <= acc_d;
      work_q     <= work_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
